// File: rtl/motor_pkg.sv
// motor_pkg: shared types and constants
// for the stepper drive slice.
package motor_pkg;

  localparam int POS_W_DEF = 8;
  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN_P,
    RUN_N,
    HOME
  } state_t;

  // two-phase-on patterns indexed by phase 0..3
  localparam logic [3:0][3:0] COIL_PAT = {
    4'b1001, 4'b1100, 4'b0110, 4'b0011
  };

endpackage

// File: rtl/step_divider.sv
// step_divider: step-period counter that
// emits a one-cycle tick at cnt == div.
module step_divider
  import motor_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == div);

  // count 0..div while running; restart on clear or tick
  always_ff @(posedge clk) begin
    if (!rst_n || clr || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/motor_step_ctrl.sv
// motor_step_ctrl: paced 4-phase stepper drive
// with saturating position and homing.
module motor_step_ctrl
  import motor_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    right,
  input  logic                    left,
  input  logic [DIV_W-1:0]        div,
  input  logic                    home_req,
  output logic                    home_ack,
  output logic [3:0]              coil,
  output logic signed [POS_W-1:0] pos,
  output logic                    moving,
  output logic                    at_limit
);

  localparam logic signed [POS_W-1:0] POS_MAX =
    {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN =
    {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [POS_W-1:0] POS_ONE = 1;

  state_t                  state_q;
  state_t                  state_d;
  logic [1:0]              ph_q;
  logic [1:0]              ph_d;
  logic signed [POS_W-1:0] pos_d;
  logic                    lim_d;
  logic                    tick;
  logic                    step_up;
  logic                    step_dn;
  logic                    clr;
  logic                    run;

  assign run = (state_q != IDLE);
  assign clr = (state_d != state_q);

  step_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .run  (run),
    .div  (div),
    .tick (tick)
  );

  // next state and step request; exits beat ticks
  always_comb begin
    state_d = state_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!en) state_d = IDLE;
        else if (home_req) state_d = HOME;
        else if (right && !left) state_d = RUN_P;
        else if (left && !right) state_d = RUN_N;
      end
      RUN_P: begin
        if (!en || !right || left) state_d = IDLE;
        else if (tick) step_up = 1'b1;
      end
      RUN_N: begin
        if (!en || !left || right) state_d = IDLE;
        else if (tick) step_dn = 1'b1;
      end
      HOME: begin
        if (!en || pos == '0) begin
          state_d = IDLE;
        end else if (tick) begin
          step_up = pos[POS_W-1];
          step_dn = !pos[POS_W-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // apply a step unless it would leave the range
  always_comb begin
    ph_d  = ph_q;
    pos_d = pos;
    lim_d = at_limit;
    if (step_up) begin
      if (pos == POS_MAX) begin
        lim_d = 1'b1;
      end else begin
        ph_d  = ph_q + 2'd1;
        pos_d = pos + POS_ONE;
        lim_d = 1'b0;
      end
    end else if (step_dn) begin
      if (pos == POS_MIN) begin
        lim_d = 1'b1;
      end else begin
        ph_d  = ph_q - 2'd1;
        pos_d = pos - POS_ONE;
        lim_d = 1'b0;
      end
    end
    if (clr || !(state_d inside {RUN_P, RUN_N})) begin
      lim_d = 1'b0;
    end
  end

  // state, phase, position and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ph_q     <= 2'd0;
      pos      <= '0;
      coil     <= 4'b0000;
      moving   <= 1'b0;
      home_ack <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      pos      <= pos_d;
      coil     <= en ? COIL_PAT[ph_d] : 4'b0000;
      moving   <= (state_d != IDLE);
      home_ack <= (state_d == HOME) && (pos_d == '0);
      at_limit <= lim_d;
    end
  end

endmodule

// File: tb/tb_motor_step_ctrl.sv
// tb_motor_step_ctrl: vector table, corner
// sequences and random run against a model.
module tb_motor_step_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              right;
  logic              left;
  logic [7:0]        div;
  logic              home_req;
  logic              home_ack;
  logic [3:0]        coil;
  logic signed [7:0] pos;
  logic              moving;
  logic              at_limit;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 run+, 2 run-, 3 home
  int         m_mode;
  int         m_k;
  int         m_pos;
  bit         m_lim;
  bit         m_ack;
  bit         m_mv;
  logic [3:0] m_coil;

  localparam int MAXP = 127;
  localparam int MINP = -128;

  motor_step_ctrl #(
    .POS_W(8),
    .DIV_W(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .right   (right),
    .left    (left),
    .div     (div),
    .home_req(home_req),
    .home_ack(home_ack),
    .coil    (coil),
    .pos     (pos),
    .moving  (moving),
    .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  // phase equals position mod 4, pattern is 0011 rotated left
  function automatic logic [3:0] pat(int p);
    logic [7:0] t;
    t = 8'h33;
    t = t << (p & 3);
    return t[7:4];
  endfunction

  task automatic try_move(int d);
    if (m_pos + d > MAXP || m_pos + d < MINP) begin
      m_lim = 1'b1;
    end else begin
      m_pos = m_pos + d;
      m_lim = 1'b0;
    end
  endtask

  // advance model by one clock using the inputs now applied
  task automatic model_edge();
    int nm;
    bit tk;
    if (!rst_n) begin
      m_mode = 0; m_k = 0; m_pos = 0;
      m_lim = 0; m_ack = 0; m_mv = 0;
      m_coil = 4'b0000;
      return;
    end
    nm = m_mode;
    tk = (m_k % (int'(div) + 1)) == int'(div);
    if (!en) begin
      nm = 0;
    end else begin
      case (m_mode)
        0: begin
          if (home_req) nm = 3;
          else if (right && !left) nm = 1;
          else if (left && !right) nm = 2;
        end
        1: begin
          if (!right || left) nm = 0;
          else if (tk) try_move(1);
        end
        2: begin
          if (!left || right) nm = 0;
          else if (tk) try_move(-1);
        end
        default: begin
          if (m_pos == 0) nm = 0;
          else if (tk) m_pos = m_pos + ((m_pos > 0) ? -1 : 1);
        end
      endcase
    end
    if (nm != m_mode) begin
      m_k = 0;
      m_lim = 1'b0;
    end else begin
      m_k = m_k + 1;
    end
    m_mode = nm;
    m_ack  = (nm == 3) && (m_pos == 0);
    m_mv   = (nm != 0);
    m_coil = en ? pat(m_pos) : 4'b0000;
  endtask

  task automatic chk_model(string tag);
    checks++;
    if (coil !== m_coil || pos !== 8'(m_pos) ||
        moving !== m_mv || home_ack !== m_ack ||
        at_limit !== m_lim) begin
      errors++;
      $display("FAIL %s t=%0t: got coil=%b pos=%0d mv=%b ack=%b lim=%b, want coil=%b pos=%0d mv=%b ack=%b lim=%b",
               tag, $time, coil, pos, moving, home_ack, at_limit,
               m_coil, m_pos, m_mv, m_ack, m_lim);
    end
  endtask

  task automatic exp_eq(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d want %0d",
               tag, $time, act, exp);
    end
  endtask

  task automatic step(string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    bit         en;
    bit         r;
    bit         l;
    bit         h;
    int         dv;
    logic [3:0] coil;
    int         pos;
    bit         mv;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit e, bit r, bit l, bit h, int dv,
                     logic [3:0] c, int p, bit mv);
    vec_t v;
    v.en = e; v.r = r; v.l = l; v.h = h; v.dv = dv;
    v.coil = c; v.pos = p; v.mv = mv;
    tbl.push_back(v);
  endtask

  int acks;

  initial begin
    // run positive at div=3: first step 5 edges after request
    add(1, 0, 0, 0, 3, 4'b0011, 0, 0);
    add(1, 1, 0, 0, 3, 4'b0011, 0, 1);
    add(1, 1, 0, 0, 3, 4'b0011, 0, 1);
    add(1, 1, 0, 0, 3, 4'b0011, 0, 1);
    add(1, 1, 0, 0, 3, 4'b0011, 0, 1);
    add(1, 1, 0, 0, 3, 4'b0110, 1, 1);
    add(1, 1, 0, 0, 3, 4'b0110, 1, 1);
    add(1, 1, 0, 0, 3, 4'b0110, 1, 1);
    add(1, 1, 0, 0, 3, 4'b0110, 1, 1);
    add(1, 1, 0, 0, 3, 4'b1100, 2, 1);
    add(1, 1, 0, 0, 3, 4'b1100, 2, 1);
    add(1, 1, 0, 0, 3, 4'b1100, 2, 1);
    add(1, 1, 0, 0, 3, 4'b1100, 2, 1);
    add(1, 1, 0, 0, 3, 4'b1001, 3, 1);
    add(1, 1, 0, 0, 3, 4'b1001, 3, 1);
    add(1, 1, 0, 0, 3, 4'b1001, 3, 1);
    add(1, 1, 0, 0, 3, 4'b1001, 3, 1);
    add(1, 1, 0, 0, 3, 4'b0011, 4, 1);
    add(1, 0, 0, 0, 3, 4'b0011, 4, 0);

    rst_n = 1'b0; en = 1'b1; right = 1'b0; left = 1'b0;
    home_req = 1'b0; div = 8'd3;
    for (int i = 0; i < 3; i++) step("reset");
    exp_eq("reset_coil", int'(coil), 0);
    exp_eq("reset_pos", int'(pos), 0);
    exp_eq("reset_moving", int'(moving), 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; right = tbl[i].r; left = tbl[i].l;
      home_req = tbl[i].h; div = 8'(tbl[i].dv);
      step("vec_model");
      checks++;
      if (coil !== tbl[i].coil || pos !== 8'(tbl[i].pos) ||
          moving !== tbl[i].mv || home_ack !== 1'b0 ||
          at_limit !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d: got coil=%b pos=%0d mv=%b, want coil=%b pos=%0d mv=%b",
                 i, coil, pos, moving, tbl[i].coil, tbl[i].pos, tbl[i].mv);
      end
    end

    // reversal on a tick cycle: exit wins, then one IDLE cycle
    right = 1'b1;
    step("rev_enter");
    for (int i = 0; i < 3; i++) step("rev_wait");
    right = 1'b0; left = 1'b1;
    step("rev_exit");
    exp_eq("rev_nostep_pos", int'(pos), 4);
    exp_eq("rev_idle", int'(moving), 0);
    step("rev_run_n");
    exp_eq("rev_run_n_moving", int'(moving), 1);
    for (int i = 0; i < 3; i++) step("rev_wait2");
    exp_eq("rev_hold_pos", int'(pos), 4);
    step("rev_step");
    exp_eq("rev_step_pos", int'(pos), 3);
    exp_eq("rev_step_coil", int'(coil), 9);

    // saturation at the negative limit
    div = 8'd0;
    for (int i = 0; i < 300 && m_pos != MINP; i++) step("sat_run");
    exp_eq("sat_reached", int'(pos), MINP);
    for (int i = 0; i < 3; i++) begin
      step("sat_hold");
      exp_eq("sat_lim", int'(at_limit), 1);
      exp_eq("sat_pos", int'(pos), MINP);
      exp_eq("sat_coil", int'(coil), 3);
    end
    left = 1'b0; right = 1'b1;
    step("sat_leave");
    exp_eq("sat_leave_lim", int'(at_limit), 0);
    step("sat_enter_p");
    step("sat_first_p");
    exp_eq("sat_first_p_pos", int'(pos), MINP + 1);
    exp_eq("sat_first_p_lim", int'(at_limit), 0);
    exp_eq("sat_first_p_coil", int'(coil), 6);

    // homing from pos 5 with div 0
    right = 1'b0;
    rst_n = 1'b0;
    step("home_rst");
    rst_n = 1'b1; right = 1'b1;
    step("home_prep");
    for (int i = 0; i < 5; i++) step("home_prep_run");
    right = 1'b0;
    step("home_prep_idle");
    exp_eq("home_start_pos", int'(pos), 5);
    home_req = 1'b1;
    acks = 0;
    step("home_enter");
    for (int i = 0; i < 5; i++) begin
      step("home_step");
      if (home_ack) acks++;
    end
    exp_eq("home_pos0", int'(pos), 0);
    exp_eq("home_ack_hi", int'(home_ack), 1);
    step("home_done");
    if (home_ack) acks++;
    exp_eq("home_ack_once", acks, 1);
    exp_eq("home_idle", int'(moving), 0);
    step("home_zero_enter");
    exp_eq("home_zero_ack", int'(home_ack), 1);
    home_req = 1'b0;
    step("home_zero_exit");
    exp_eq("home_zero_ack_off", int'(home_ack), 0);
    exp_eq("home_zero_idle", int'(moving), 0);

    // enable drop mid-run holds position, blanks coils
    right = 1'b1;
    step("abort_enter");
    for (int i = 0; i < 3; i++) step("abort_run");
    en = 1'b0;
    step("abort_en");
    exp_eq("abort_coil", int'(coil), 0);
    exp_eq("abort_pos", int'(pos), 3);
    exp_eq("abort_moving", int'(moving), 0);
    en = 1'b1; right = 1'b0;
    step("abort_resume");
    exp_eq("abort_resume_coil", int'(coil), 9);

    // reset mid-HOME: no ack, position cleared
    home_req = 1'b1; div = 8'd5;
    step("rh_enter");
    for (int i = 0; i < 4; i++) step("rh_wait");
    rst_n = 1'b0;
    step("rh_reset");
    exp_eq("rh_pos", int'(pos), 0);
    exp_eq("rh_ack", int'(home_ack), 0);
    exp_eq("rh_moving", int'(moving), 0);
    rst_n = 1'b1; home_req = 1'b0;
    step("rh_release");

    // random traffic; div changes only with en low
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) right = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) left = 1'($urandom_range(0, 1));
      home_req = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 63) == 0) begin
        en = 1'b0;
        div = 8'($urandom_range(0, 3));
      end else begin
        en = 1'b1;
      end
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_step_ctrl.md
# motor_step_ctrl

Step-sequencing controller that sits downstream of the direction FSM and turns its `right`/`left` decisions into a paced 4-phase stepper-coil drive. It tracks a signed position, saturates at the position limits and supports a homing request/acknowledge handshake. While homing it owns the coils and ignores the direction inputs. It is the only block that drives the motor coil pins.

## Interface
Parameters:
- `POS_W`, default 8: width of the signed position counter (two's complement).
- `DIV_W`, default 8: width of the step-period divider.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `en`, input, 1: drive enable; 0 forces coils off and the FSM to IDLE.
- `right`, input, 1: step-positive request (level), from the direction FSM.
- `left`, input, 1: step-negative request (level), from the direction FSM.
- `div`, input, DIV_W: step period minus 1, in clocks; sampled every cycle.
- `home_req`, input, 1: level request to drive position back to 0.
- `home_ack`, output, 1: one-cycle pulse when homing completes.
- `coil`, output, 4: registered coil drive pattern.
- `pos`, output, POS_W: signed step position.
- `moving`, output, 1: 1 in RUN_P, RUN_N and HOME.
- `at_limit`, output, 1: 1 while a step is being suppressed by saturation.

## Operation
- Phase index `ph` is 0..3 and wraps mod 4. Two-phase-on patterns: ph0=0011, ph1=0110, ph2=1100, ph3=1001.
- A positive step sets ph+1 and pos+1. A negative step sets ph-1 and pos-1.
- Every output is a register. `coil` = en ? pattern[next ph] : 0000.
- FSM states: IDLE, RUN_P, RUN_N, HOME.
- IDLE transitions are evaluated in priority order:
  - `en`=0 → stay.
  - `home_req` → HOME.
  - `right`&!`left` → RUN_P.
  - `left`&!`right` → RUN_N.
  - Both or neither → stay.
- RUN_P exits to IDLE when `right`=0, `left`=1 or `en`=0. RUN_N is the mirror case.
- A direction reversal always passes through IDLE, which inserts one dead cycle plus a full divider period.
- HOME:
  - Steps toward 0 at the divider rate: negative if pos>0, positive if pos<0.
  - `right`, `left` and `home_req` are ignored while in HOME.
  - When pos==0, pulse `home_ack` and go to IDLE.
  - `en`=0 aborts to IDLE with no ack.
- Saturation:
  - pos is clamped to [-2^(POS_W-1), 2^(POS_W-1)-1].
  - A step that would exceed the range is suppressed: ph, pos and coil are held and `at_limit`=1 for that tick.
  - `at_limit` clears on the next non-suppressed tick or on leaving RUN.
- `en`=0 in any state:
  - Next cycle: `coil`=0000, state IDLE, divider cleared.
  - ph and pos are held.
- Reset (`rst_n`=0 at an edge):
  - state=IDLE, ph=0, pos=0, cnt=0.
  - coil=0000, moving=0, home_ack=0, at_limit=0.
  - Reset overrides everything, including mid-HOME; no ack is issued.

## Timing
- Divider `cnt` is cleared on every state entry. In RUN/HOME it counts 0..`div`.
- A tick occurs at cnt==`div`, then cnt returns to 0.
- The first step lands on the edge `div`+1 cycles after the state is entered. Subsequent steps are every `div`+1 cycles.
- `div`=0 gives one step per clock. A `div` change takes effect at the next compare.
- Request latency: a request seen at edge N puts the FSM in RUN at edge N+1. The first step is at edge N+1+`div`+1.
- Exit priority: if an exit condition and a tick coincide, the exit wins and no step is taken.
- HOME:
  - pos==0 is checked every cycle in HOME.
  - If pos is already 0 on entry, `home_ack` pulses on the first HOME cycle and the FSM returns to IDLE on the next edge.
- After `rst_n` releases with `en`=1, `coil` shows 0011 one edge later.

## Structure
- Shared package `motor_pkg` holds:
  - State enum.
  - The 4-entry coil pattern constant array.
  - Default values for `POS_W`/`DIV_W`.
- Sub-module `step_divider` (DIV_W counter with clear, enable and `div` compare) produces a one-cycle `tick`.
- FSM, phase, position and saturation logic stay in `motor_step_ctrl`.

## Test plan
- Reset: `rst_n`=0 for 3 cycles with en=1 → coil=0000, pos=0, moving=0. One edge after release → coil=0011.
- Run positive: div=3, right=1 → first step 5 edges after right is sampled, then every 4 cycles. coil goes 0110, 1100, 1001, 0011; pos goes 1, 2, 3, 4.
- Reversal: while in RUN_P, set right=0 and left=1 on a tick cycle → no step that edge, one IDLE cycle, then RUN_N. The first negative step arrives div+1 cycles later and coil steps backward.
- Saturation: POS_W=8, pos=-128, left=1, div=0 → pos stays -128, coil is frozen and at_limit=1 every cycle. Setting right=1 clears at_limit on the first positive step.
- Homing: pos=5, div=0, home_req=1 → 5 negative steps, pos=0, then `home_ack` high for exactly 1 cycle, then IDLE. Repeat from pos=0 → ack on the first HOME cycle.
- Abort: drop en mid-run → coil=0000 the next cycle with pos held. Assert `rst_n`=0 mid-HOME → IDLE, pos=0, no home_ack.
